regfile_sequencer: RTL and testbench



---
 rtl/regfile_sequencer_if.sv | 30 +++
 rtl/regfile_sequencer.sv | 147 ++++++++++++++
 tb/tb_regfile_sequencer.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_sequencer_if.sv
// Command handshake, ALU handshake and register-file control bundle for the sequencer.
// The sequencer side uses the slave modport; the decoder/register-file/ALU side uses master.
interface regfile_sequencer_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_op;
    logic [2:0] cmd_rd;
    logic [2:0] cmd_rs;
    logic [7:0] cmd_imm;
    logic [7:0] or2_out;
    logic [2:0] mux_sel;
    logic [2:0] reg_sel;
    logic [2:0] seg;
    logic [1:0] enab;
    logic       alu_start;
    logic       alu_done;
    logic       busy;
    logic       done;
    logic       err;

    modport master (
        output cmd_valid, cmd_op, cmd_rd, cmd_rs, cmd_imm, alu_done,
        input  cmd_ready, or2_out, mux_sel, reg_sel, seg, enab, alu_start, busy, done, err
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_rd, cmd_rs, cmd_imm, alu_done,
        output cmd_ready, or2_out, mux_sel, reg_sel, seg, enab, alu_start, busy, done, err
    );
endinterface

// File: rtl/regfile_sequencer.sv
// Multi-cycle FSM driving the 8x8 register file controls; done 1 cycle after accept (NOP/illegal), 2 (moves), or 2 after alu_done.
// One command in flight: cmd_ready only in IDLE, so a held cmd_valid waits until the current command finishes.
module regfile_sequencer #(
    parameter int unsigned ALU_TIMEOUT = 15
) (
    input  logic               clk,
    input  logic               rst,
    regfile_sequencer_if.slave bus
);
    localparam logic [2:0] OP_NOP  = 3'b000;
    localparam logic [2:0] OP_CLR  = 3'b001;
    localparam logic [2:0] OP_LDI  = 3'b010;
    localparam logic [2:0] OP_MOV  = 3'b011;
    localparam logic [2:0] OP_MOVA = 3'b100;
    localparam logic [2:0] OP_ALU  = 3'b101;
    localparam logic [3:0] WAIT_LAST = 4'(ALU_TIMEOUT - 1);

    typedef enum logic [2:0] {IDLE, EXEC, READ, WAIT, WRITE, FIN} state_t;

    state_t     state, state_nxt;
    logic [2:0] op_q, rd_q, rs_q;
    logic [7:0] or2_q;
    logic [3:0] wait_cnt;
    logic       err_q;
    logic       accept;
    logic       timeout;

    assign accept  = (state == IDLE) && bus.cmd_valid;
    // alu_done on the terminal count still counts as a response, not a timeout
    assign timeout = (state == WAIT) && !bus.alu_done && (wait_cnt == WAIT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            op_q     <= 3'd0;
            rd_q     <= 3'd0;
            rs_q     <= 3'd0;
            or2_q    <= 8'd0;
            wait_cnt <= 4'd0;
            err_q    <= 1'b0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= (state == WAIT) ? wait_cnt + 4'd1 : 4'd0;
            if (accept) begin
                op_q  <= bus.cmd_op;
                rd_q  <= bus.cmd_rd;
                rs_q  <= bus.cmd_rs;
                err_q <= (bus.cmd_op > OP_ALU);
                if (bus.cmd_op == OP_LDI) begin
                    or2_q <= bus.cmd_imm;
                end
            end else if (timeout) begin
                err_q <= 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt     = state;
        bus.cmd_ready = 1'b0;
        bus.busy      = (state != IDLE);
        bus.done      = 1'b0;
        bus.err       = 1'b0;
        bus.alu_start = 1'b0;
        bus.enab      = 2'b10;
        bus.mux_sel   = 3'b000;
        bus.reg_sel   = 3'd0;
        bus.seg       = 3'd0;
        bus.or2_out   = or2_q;

        case (state)
            IDLE: begin
                bus.cmd_ready = 1'b1;
                if (bus.cmd_valid) begin
                    case (bus.cmd_op)
                        OP_ALU:                          state_nxt = READ;
                        OP_CLR, OP_LDI, OP_MOV, OP_MOVA: state_nxt = EXEC;
                        OP_NOP:                          state_nxt = FIN;
                        default:                         state_nxt = FIN;
                    endcase
                end
            end
            EXEC: begin
                state_nxt = FIN;
                case (op_q)
                    OP_CLR: bus.enab = 2'b00;
                    OP_LDI: begin
                        bus.enab    = 2'b01;
                        bus.mux_sel = 3'b010;
                        bus.seg     = rd_q;
                    end
                    OP_MOV: begin
                        bus.enab    = 2'b01;
                        bus.mux_sel = 3'b001;
                        bus.reg_sel = rs_q;
                        bus.seg     = rd_q;
                    end
                    OP_MOVA: begin
                        bus.enab    = 2'b01;
                        bus.mux_sel = 3'b000;
                        bus.seg     = rd_q;
                    end
                    default: ;
                endcase
            end
            READ: begin
                bus.enab  = 2'b11;
                bus.seg   = rs_q;
                state_nxt = WAIT;
            end
            WAIT: begin
                bus.alu_start = (wait_cnt == 4'd0);
                if (bus.alu_done) begin
                    state_nxt = WRITE;
                end else if (wait_cnt == WAIT_LAST) begin
                    state_nxt = FIN;
                end
            end
            WRITE: begin
                bus.enab    = 2'b01;
                bus.mux_sel = 3'b011;
                bus.seg     = rd_q;
                state_nxt   = FIN;
            end
            FIN: begin
                bus.done  = 1'b1;
                bus.err   = err_q;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase

        // reset overrides everything, including the clear of the register file
        if (rst) begin
            bus.cmd_ready = 1'b0;
            bus.busy      = 1'b0;
            bus.done      = 1'b0;
            bus.err       = 1'b0;
            bus.alu_start = 1'b0;
            bus.enab      = 2'b00;
            bus.mux_sel   = 3'b000;
            bus.reg_sel   = 3'd0;
            bus.seg       = 3'd0;
            bus.or2_out   = 8'd0;
        end
    end
endmodule

// File: tb/tb_regfile_sequencer.sv
// Randomized command stream against a per-command timeline model, plus directed literal checks.
module tb_regfile_sequencer;
    localparam int T    = 15;
    localparam int LOGN = 8192;

    typedef struct packed {
        logic       rdy;
        logic       bsy;
        logic       dn;
        logic       er;
        logic       st;
        logic [1:0] enab;
        logic [2:0] mux;
        logic [2:0] rsel;
        logic [2:0] seg;
        logic [7:0] or2;
    } rec_t;

    typedef struct packed {
        logic [2:0] op;
        logic [2:0] rd;
        logic [2:0] rs;
        logic [7:0] imm;
    } cmd_t;

    logic clk = 1'b0;
    logic rst;
    regfile_sequencer_if bus ();

    regfile_sequencer #(.ALU_TIMEOUT(T)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    rec_t cur;
    rec_t lg [0:LOGN-1];
    logic [7:0] m_or2;
    rec_t tl [$];

    function automatic rec_t base_rec(input bit idle);
        rec_t r;
        r      = '0;
        r.enab = 2'b10;
        r.or2  = m_or2;
        r.rdy  = idle;
        r.bsy  = !idle;
        return r;
    endfunction

    function automatic cmd_t mk(input logic [2:0] op, input logic [2:0] rd,
                                input logic [2:0] rs, input logic [7:0] imm);
        cmd_t c;
        c.op = op; c.rd = rd; c.rs = rs; c.imm = imm;
        return c;
    endfunction

    function automatic cmd_t rnd_cmd();
        return mk(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                  3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)));
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    // one cycle: sample away from the edge, log, compare against model, advance
    task automatic tick();
        rec_t d;
        @(negedge clk);
        d.rdy = bus.cmd_ready; d.bsy = bus.busy; d.dn = bus.done; d.er = bus.err;
        d.st = bus.alu_start; d.enab = bus.enab; d.mux = bus.mux_sel;
        d.rsel = bus.reg_sel; d.seg = bus.seg; d.or2 = bus.or2_out;
        if (cyc < LOGN) lg[cyc] = d;
        total++;
        if (d !== cur) begin
            bad++;
            $display("FAIL cycle_check cyc=%0d got rdy=%0d bsy=%0d dn=%0d er=%0d st=%0d enab=%b mux=%b rsel=%0d seg=%0d or2=%h want rdy=%0d bsy=%0d dn=%0d er=%0d st=%0d enab=%b mux=%b rsel=%0d seg=%0d or2=%h",
                     cyc, d.rdy, d.bsy, d.dn, d.er, d.st, d.enab, d.mux, d.rsel, d.seg, d.or2,
                     cur.rdy, cur.bsy, cur.dn, cur.er, cur.st, cur.enab, cur.mux, cur.rsel, cur.seg, cur.or2);
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic drive(input cmd_t c, input bit v);
        bus.cmd_valid = v;
        bus.cmd_op    = c.op;
        bus.cmd_rd    = c.rd;
        bus.cmd_rs    = c.rs;
        bus.cmd_imm   = c.imm;
    endtask

    task automatic idle_gap(input int n);
        for (int i = 0; i < n; i++) begin
            bus.cmd_valid = 1'b0;
            bus.alu_done  = 1'($urandom_range(0, 1));
            cur = base_rec(1);
            tick();
        end
    endtask

    // present c in an IDLE cycle, then walk the command's expected timeline;
    // d = cycles from alu_start to alu_done (>= T means the ALU never answers)
    task automatic run_cmd(input cmd_t c, input int d, input bit has_nxt, input cmd_t nxt,
                           input int rst_at, output int n);
        rec_t r;
        bit   alu_ok;
        int   nwait;
        drive(c, 1'b1);
        bus.alu_done = 1'($urandom_range(0, 1));
        cur = base_rec(1);
        n = cyc;
        tick();
        if (c.op == 3'b010) m_or2 = c.imm;
        alu_ok = (d < T);
        nwait  = alu_ok ? d + 1 : T;
        tl.delete();
        case (c.op)
            3'b001: begin r = base_rec(0); r.enab = 2'b00; tl.push_back(r); end
            3'b010: begin r = base_rec(0); r.enab = 2'b01; r.mux = 3'b010; r.seg = c.rd; tl.push_back(r); end
            3'b011: begin r = base_rec(0); r.enab = 2'b01; r.mux = 3'b001; r.rsel = c.rs; r.seg = c.rd; tl.push_back(r); end
            3'b100: begin r = base_rec(0); r.enab = 2'b01; r.mux = 3'b000; r.seg = c.rd; tl.push_back(r); end
            3'b101: begin
                r = base_rec(0); r.enab = 2'b11; r.seg = c.rs; tl.push_back(r);
                for (int k = 0; k < nwait; k++) begin
                    r = base_rec(0); r.st = (k == 0); tl.push_back(r);
                end
                if (alu_ok) begin
                    r = base_rec(0); r.enab = 2'b01; r.mux = 3'b011; r.seg = c.rd; tl.push_back(r);
                end
            end
            default: ;
        endcase
        r = base_rec(0);
        r.dn = 1'b1;
        r.er = (c.op >= 3'b110) || (c.op == 3'b101 && !alu_ok);
        tl.push_back(r);

        for (int i = 0; i < tl.size(); i++) begin
            if (i == rst_at) begin
                rst = 1'b1;
                bus.cmd_valid = 1'b0;
                bus.alu_done  = 1'($urandom_range(0, 1));
                cur = '0;
                tick();
                rst   = 1'b0;
                m_or2 = 8'd0;
                break;
            end
            drive(nxt, has_nxt);
            if (c.op == 3'b101 && i >= 1 && i <= nwait) bus.alu_done = (i - 1 == d);
            else bus.alu_done = 1'($urandom_range(0, 1));
            cur = tl[i];
            tick();
        end
        cur = base_rec(1);
    endtask

    int   r0, r1, n_ldi, n_mov, n_mova, n_alu, n_to, n_ill, n_rw, n, cnt;
    cmd_t z, c, nx;
    bit   hn;
    int   ra, dly;

    initial begin
        z = '0;
        rst = 1'b1;
        drive(z, 1'b0);
        bus.alu_done = 1'b0;
        m_or2 = 8'd0;
        @(posedge clk);
        #1;
        cur = '0;
        r0 = cyc;
        tick();
        tick();
        rst = 1'b0;
        cur = base_rec(1);
        r1 = cyc;
        tick();

        run_cmd(mk(3'b010, 3'd3, 3'd0, 8'hA5), 0, 1'b0, z, -1, n_ldi);
        idle_gap(1);
        run_cmd(mk(3'b011, 3'd5, 3'd2, 8'h00), 0, 1'b1, mk(3'b100, 3'd6, 3'd0, 8'h00), -1, n_mov);
        run_cmd(mk(3'b100, 3'd6, 3'd0, 8'h00), 0, 1'b0, z, -1, n_mova);
        idle_gap(1);
        run_cmd(mk(3'b101, 3'd4, 3'd1, 8'h00), 3, 1'b0, z, -1, n_alu);
        idle_gap(1);
        run_cmd(mk(3'b101, 3'd2, 3'd7, 8'h00), 40, 1'b0, z, -1, n_to);
        idle_gap(1);
        run_cmd(mk(3'b110, 3'd1, 3'd1, 8'h00), 0, 1'b0, z, -1, n_ill);
        idle_gap(1);
        run_cmd(mk(3'b101, 3'd0, 3'd3, 8'h00), 40, 1'b0, z, 3, n_rw);
        idle_gap(2);

        chk("rst_enab_c0", 32'(lg[r0].enab), 32'h0);
        chk("rst_enab_c1", 32'(lg[r0+1].enab), 32'h0);
        chk("rst_rdy_c1", 32'(lg[r0+1].rdy), 32'h0);
        chk("post_rst_enab", 32'(lg[r1].enab), 32'h2);
        chk("post_rst_rdy", 32'(lg[r1].rdy), 32'h1);
        chk("post_rst_busy", 32'(lg[r1].bsy), 32'h0);
        chk("ldi_exec", {lg[n_ldi+1].enab, lg[n_ldi+1].mux, lg[n_ldi+1].seg, lg[n_ldi+1].or2}, {16'h0, 2'b01, 3'b010, 3'd3, 8'hA5});
        chk("ldi_done", {lg[n_ldi+2].dn, lg[n_ldi+2].er}, 32'h2);
        chk("ldi_ready_after", 32'(lg[n_ldi+3].rdy), 32'h1);
        chk("mov_exec", {lg[n_mov+1].enab, lg[n_mov+1].mux, lg[n_mov+1].rsel, lg[n_mov+1].seg}, {21'h0, 2'b01, 3'b001, 3'd2, 3'd5});
        chk("mov_busy_rdy", 32'(lg[n_mov+2].rdy), 32'h0);
        chk("mova_exec", {lg[n_mova+1].enab, lg[n_mova+1].mux, lg[n_mova+1].seg}, {24'h0, 2'b01, 3'b000, 3'd6});
        chk("alu_read", {lg[n_alu+1].enab, lg[n_alu+1].seg}, {27'h0, 2'b11, 3'd1});
        chk("alu_start_pulse", {lg[n_alu+2].st, lg[n_alu+3].st}, 32'h2);
        chk("alu_write", {lg[n_alu+6].enab, lg[n_alu+6].mux, lg[n_alu+6].seg}, {24'h0, 2'b01, 3'b011, 3'd4});
        chk("alu_done", {lg[n_alu+7].dn, lg[n_alu+7].er}, 32'h2);
        cnt = 0;
        for (int i = 1; i <= 17; i++) if (lg[n_to+i].enab == 2'b01) cnt++;
        chk("to_no_write", 32'(cnt), 32'h0);
        chk("to_not_early", 32'(lg[n_to+16].dn), 32'h0);
        chk("to_done_err", {lg[n_to+17].dn, lg[n_to+17].er}, 32'h3);
        chk("to_idle", 32'(lg[n_to+18].rdy), 32'h1);
        chk("ill_done_err", {lg[n_ill+1].dn, lg[n_ill+1].er, lg[n_ill+1].enab}, {28'h0, 2'b11, 2'b10});
        chk("rw_rst_enab", 32'(lg[n_rw+4].enab), 32'h0);
        chk("rw_idle", {lg[n_rw+5].rdy, lg[n_rw+5].bsy, lg[n_rw+5].enab}, {28'h0, 1'b1, 1'b0, 2'b10});
        cnt = 0;
        for (int i = 1; i <= 6; i++) if (lg[n_rw+i].dn) cnt++;
        chk("rw_no_done", 32'(cnt), 32'h0);

        c = rnd_cmd();
        for (int k = 0; k < 150; k++) begin
            nx  = rnd_cmd();
            hn  = ($urandom_range(0, 2) == 0);
            ra  = ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, 3)) : -1;
            if (ra >= 0) hn = 1'b0;
            dly = int'($urandom_range(0, 17));
            run_cmd(c, dly, hn, nx, ra, n);
            if (!hn) idle_gap(int'($urandom_range(0, 2)));
            c = nx;
        end
        idle_gap(1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
